// File: rtl/vending_pkg.sv
// Shared types and constants for the vending datapath.
// Coin values are expressed in nickel (5c) units throughout.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_EJECT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } disp_state_t;

    typedef enum logic [1:0] {
        COIN_NICKLE  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2
    } coin_t;

    localparam int NICKLE_VAL  = 1;
    localparam int DIME_VAL    = 2;
    localparam int QUARTER_VAL = 5;

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: largest coin whose value does not exceed the amount owed.
// Purely combinational; the caller registers the result.
module coin_select
    import vending_pkg::*;
#(
    parameter int COIN_W = 3
) (
    input  logic [COIN_W-1:0] remain,
    output coin_t             coin,
    output logic [COIN_W-1:0] value
);

    always_comb begin
        coin  = COIN_NICKLE;
        value = COIN_W'(NICKLE_VAL);
        if (remain >= COIN_W'(QUARTER_VAL)) begin
            coin  = COIN_QUARTER;
            value = COIN_W'(QUARTER_VAL);
        end else if (remain >= COIN_W'(DIME_VAL)) begin
            coin  = COIN_DIME;
            value = COIN_W'(DIME_VAL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time through a four-phase hopper
// handshake, with a per-edge timeout that parks the block in a sticky fault.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int COIN_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_change_vld,
    input  logic [COIN_W-1:0] i_change,
    output logic              o_ready,
    output logic              o_eject_nickle,
    output logic              o_eject_dime,
    output logic              o_eject_quarter,
    input  logic              i_hopper_ack,
    output logic [COIN_W-1:0] o_remain,
    output logic              o_done,
    output logic              o_fault
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    disp_state_t       state_reg, state_next;
    logic [COIN_W-1:0] remain_reg, remain_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    coin_t             coin_reg, coin_next;
    logic [COIN_W-1:0] coin_val_reg, coin_val_next;

    coin_t             sel_coin;
    logic [COIN_W-1:0] sel_val;
    logic              wait_expired;

    coin_select #(
        .COIN_W (COIN_W)
    ) u_coin_select (
        .remain (remain_reg),
        .coin   (sel_coin),
        .value  (sel_val)
    );

    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            remain_reg   <= '0;
            wait_cnt_reg <= '0;
            coin_reg     <= COIN_NICKLE;
            coin_val_reg <= COIN_W'(NICKLE_VAL);
        end else begin
            state_reg    <= state_next;
            remain_reg   <= remain_next;
            wait_cnt_reg <= wait_cnt_next;
            coin_reg     <= coin_next;
            coin_val_reg <= coin_val_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        remain_next   = remain_reg;
        wait_cnt_next = wait_cnt_reg;
        coin_next     = coin_reg;
        coin_val_next = coin_val_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_change_vld) begin
                    remain_next = i_change;
                    state_next  = (i_change == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                coin_next     = sel_coin;
                coin_val_next = sel_val;
                wait_cnt_next = '0;
                state_next    = ST_EJECT;
            end
            ST_EJECT: begin
                // A level already high on entry is accepted as the ack.
                if (i_hopper_ack) begin
                    remain_next   = remain_reg - coin_val_reg;
                    wait_cnt_next = '0;
                    state_next    = ST_RELEASE;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!i_hopper_ack) begin
                    state_next = (remain_reg == '0) ? ST_DONE : ST_SELECT;
                end else if (wait_expired) begin
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        o_ready         = (state_reg == ST_IDLE);
        o_done          = (state_reg == ST_DONE);
        o_fault         = (state_reg == ST_FAULT);
        o_remain        = remain_reg;
        o_eject_nickle  = 1'b0;
        o_eject_dime    = 1'b0;
        o_eject_quarter = 1'b0;
        if (state_reg == ST_EJECT) begin
            case (coin_reg)
                COIN_NICKLE:  o_eject_nickle  = 1'b1;
                COIN_DIME:    o_eject_dime    = 1'b1;
                COIN_QUARTER: o_eject_quarter = 1'b1;
                default:      o_eject_nickle  = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboarded bench for change_dispenser: stimulus queues the expected coin
// sequence, a negedge monitor pops and compares as the hopper lines move.
module tb_change_dispenser;

    localparam int COIN_W  = 3;
    localparam int TIMEOUT = 255;
    localparam int K_COIN  = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;
    localparam int NICK = 0;
    localparam int DIME = 1;
    localparam int QUAR = 2;

    typedef struct {
        int kind;
        int coin;
        int rem;
        bit chk_rem;
        int lat;
        int gap;
    } ev_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_change_vld;
    logic [COIN_W-1:0] i_change;
    logic              o_ready;
    logic              o_eject_nickle;
    logic              o_eject_dime;
    logic              o_eject_quarter;
    logic              i_hopper_ack;
    logic [COIN_W-1:0] o_remain;
    logic              o_done;
    logic              o_fault;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_req_cyc = 0;
    bit  hop_mute = 1'b0;
    int  hold_extra = 0;
    ev_t sb[$];

    change_dispenser #(
        .COIN_W  (COIN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_change_vld    (i_change_vld),
        .i_change        (i_change),
        .o_ready         (o_ready),
        .o_eject_nickle  (o_eject_nickle),
        .o_eject_dime    (o_eject_dime),
        .o_eject_quarter (o_eject_quarter),
        .i_hopper_ack    (i_hopper_ack),
        .o_remain        (o_remain),
        .o_done          (o_done),
        .o_fault         (o_fault)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int coin, input int rem, input bit chk,
                        input int lat, input int gap);
        ev_t e;
        e.kind = kind; e.coin = coin; e.rem = rem; e.chk_rem = chk; e.lat = lat; e.gap = gap;
        sb.push_back(e);
    endtask

    // Packed view {ready, q, d, n, done, fault, remain}; reset value is ready only.
    task automatic check_reset(input string name);
        check(name, int'({o_ready, o_eject_quarter, o_eject_dime, o_eject_nickle,
                          o_done, o_fault, o_remain}), 1 << (5 + COIN_W));
    endtask

    task automatic request(input int amt);
        @(negedge i_clk);
        i_change     = COIN_W'(amt);
        i_change_vld = 1'b1;
        last_req_cyc = cyc;
        @(negedge i_clk);
        i_change_vld = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge i_clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_%s got_pending=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_txn(input string name, input int amt);
        $display("txn %s change=%0d", name, amt);
        request(amt);
        drain(name, 600);
        @(negedge i_clk); #1;
        check({name, "_ready_after"}, int'(o_ready), 1);
        check({name, "_remain_after"}, int'(o_remain), 0);
    endtask

    // Four-phase hopper: ack one cycle after eject, drop after eject falls
    // (optionally held for hold_extra extra cycles); mute never acks.
    initial begin
        i_hopper_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (hop_mute) begin
                i_hopper_ack = 1'b0;
            end else if ((o_eject_nickle | o_eject_dime | o_eject_quarter) && !i_hopper_ack) begin
                i_hopper_ack = 1'b1;
            end else if (!(o_eject_nickle | o_eject_dime | o_eject_quarter) && i_hopper_ack) begin
                if (hold_extra > 0) hold_extra--;
                else i_hopper_ack = 1'b0;
            end
        end
    end

    logic [2:0] ej;
    logic [2:0] prev_ej = 3'b000;
    bit         prev_fault = 1'b0;
    bit         pend_chk = 1'b0;
    int         pend_rem = 0;
    int         lowcnt = 0;
    int         hicnt = 0;
    int         cidx;
    ev_t        e;

    initial begin
        forever begin
            @(negedge i_clk);
            ej = {o_eject_quarter, o_eject_dime, o_eject_nickle};
            if (i_rst_n) begin
                check("eject_onehot", int'($countones(ej) <= 1), 1);
                if (ej != 3'b000 && prev_ej == 3'b000) begin
                    hicnt = 1;
                    case (ej)
                        3'b001:  cidx = NICK;
                        3'b010:  cidx = DIME;
                        3'b100:  cidx = QUAR;
                        default: cidx = -1;
                    endcase
                    check("coin_ready_low", int'(o_ready), 0);
                    if (sb.size() == 0) begin
                        check("unexpected_eject", int'(ej), 0);
                    end else begin
                        e = sb.pop_front();
                        $display("  eject coin=%0d remain=%0d t=%0t", cidx, o_remain, $time);
                        check("coin_kind", K_COIN, e.kind);
                        check("coin_type", cidx, e.coin);
                        if (e.lat >= 0) check("coin_latency", cyc - last_req_cyc, e.lat);
                        if (e.gap >= 0) check("coin_gap", lowcnt, e.gap);
                        pend_rem = e.rem;
                        pend_chk = e.chk_rem;
                    end
                end else if (ej != 3'b000) begin
                    hicnt++;
                end else if (prev_ej != 3'b000) begin
                    lowcnt = 1;
                    if (pend_chk) check("remain_after_coin", int'(o_remain), pend_rem);
                    pend_chk = 1'b0;
                end else begin
                    lowcnt++;
                end

                if (o_done) begin
                    check("done_ready_low", int'(o_ready), 0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", int'(o_done), 0);
                    end else begin
                        e = sb.pop_front();
                        $display("  done remain=%0d t=%0t", o_remain, $time);
                        check("done_kind", K_DONE, e.kind);
                        if (e.lat >= 0) check("done_latency", cyc - last_req_cyc, e.lat);
                        if (e.gap >= 0) check("done_gap", lowcnt, e.gap);
                    end
                end

                if (o_fault && !prev_fault) begin
                    if (sb.size() == 0) begin
                        check("unexpected_fault", int'(o_fault), 0);
                    end else begin
                        e = sb.pop_front();
                        $display("  fault remain=%0d eject_cycles=%0d t=%0t", o_remain, hicnt, $time);
                        check("fault_kind", K_FAULT, e.kind);
                        check("fault_remain", int'(o_remain), e.rem);
                        check("fault_eject_low", int'(ej), 0);
                        check("fault_ready_low", int'(o_ready), 0);
                        checks++;
                        if (hicnt < TIMEOUT || hicnt > TIMEOUT + 1) begin
                            failures++;
                            $display("FAIL fault_hold got=%0d exp=%0d..%0d", hicnt, TIMEOUT, TIMEOUT + 1);
                        end
                    end
                end
            end else begin
                pend_chk = 1'b0;
                lowcnt   = 0;
            end
            prev_ej    = ej;
            prev_fault = o_fault;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rises;
        bit prev_d;

        i_rst_n      = 1'b0;
        i_change_vld = 1'b0;
        i_change     = '0;
        repeat (2) @(negedge i_clk);
        #1 check_reset("reset_values");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        push(K_COIN, DIME, 2, 1'b1, 2, -1);
        push(K_COIN, DIME, 0, 1'b1, -1, 2);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c4", 4);

        push(K_COIN, QUAR, 2, 1'b1, 2, -1);
        push(K_COIN, DIME, 0, 1'b1, -1, 2);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c7", 7);

        push(K_COIN, DIME, 1, 1'b1, 2, -1);
        push(K_COIN, NICK, 0, 1'b1, -1, 2);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c3", 3);

        push(K_COIN, NICK, 0, 1'b1, 2, -1);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c1", 1);

        push(K_COIN, QUAR, 1, 1'b1, 2, -1);
        push(K_COIN, NICK, 0, 1'b1, -1, 2);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c6", 6);

        push(K_DONE, 0, 0, 1'b0, 1, -1);
        run_txn("c0", 0);

        // Ack held 10 extra cycles after the quarter: RELEASE 11 + SELECT 1.
        hold_extra = 10;
        push(K_COIN, QUAR, 2, 1'b1, 2, -1);
        push(K_COIN, DIME, 0, 1'b1, -1, 12);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("c7_hold", 7);

        // Reset while the second dime of a 4 is on the hopper.
        $display("txn rst_mid change=4");
        push(K_COIN, DIME, 2, 1'b1, 2, -1);
        push(K_COIN, DIME, 0, 1'b0, -1, 2);
        request(4);
        n = 0; rises = 0; prev_d = 1'b0;
        while (rises < 2 && n < 100) begin
            @(negedge i_clk); #1;
            if (o_eject_dime && !prev_d) rises++;
            prev_d = o_eject_dime;
            n++;
        end
        check("rst_second_dime_seen", rises, 2);
        check("rst_dime_high_before", int'(o_eject_dime), 1);
        #1 i_rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(negedge i_clk); #1;
        check_reset("rst_held");
        i_rst_n = 1'b1;
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();
        push(K_COIN, DIME, 0, 1'b1, 2, -1);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("after_rst", 2);

        // Hopper never acks: quarter held until timeout, then sticky fault.
        $display("txn fault change=5");
        hop_mute = 1'b1;
        push(K_COIN, QUAR, 0, 1'b0, 2, -1);
        push(K_FAULT, 0, 5, 1'b0, -1, -1);
        request(5);
        drain("fault", TIMEOUT + 50);
        request(3);
        repeat (20) @(negedge i_clk);
        #1;
        check("fault_sticky", int'({o_fault, o_ready, o_eject_quarter, o_eject_dime,
                                    o_eject_nickle, o_remain}), (1 << (4 + COIN_W)) | 5);
        i_rst_n = 1'b0;
        #1 check_reset("fault_rst");
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        hop_mute = 1'b0;
        push(K_COIN, DIME, 0, 1'b1, 2, -1);
        push(K_DONE, 0, 0, 1'b0, -1, 2);
        run_txn("post_fault", 2);

        repeat (3) @(negedge i_clk);
        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
